// File: rtl/btn_debounce_array.sv
// Multi-channel push-button front end: polarity fix, synchroniser, stable-time
// debounce, press/release strobes, long-press detection and optional auto-repeat.
module btn_debounce_array #(
  parameter int NUM_BTNS        = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int LONG_CYCLES     = 13500000,
  parameter int REPEAT_CYCLES   = 2700000
) (
  input  logic                clk_27mhz,
  input  logic                reset_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  input  logic [NUM_BTNS-1:0] repeat_en,
  output logic [NUM_BTNS-1:0] held,
  output logic [NUM_BTNS-1:0] press,
  output logic [NUM_BTNS-1:0] release_o,
  output logic [NUM_BTNS-1:0] long_press
);

  localparam int DBW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HCW  = (LONG_CYCLES > 1)     ? $clog2(LONG_CYCLES)     : 1;
  localparam int RCW  = (REPEAT_CYCLES > 1)   ? $clog2(REPEAT_CYCLES)   : 1;

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(LONG_CYCLES - 1);
  localparam logic [RCW-1:0] RPT_LAST  = RCW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_t;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pol_s;
    logic                   s;
    logic [DBW-1:0]         db_cnt_d, db_cnt_q;
    logic                   db_d, db_q;
    state_t                 state_q;
    logic [HCW-1:0]         hold_cnt_q;
    logic [RCW-1:0]         rpt_cnt_q;
    logic                   held_q, press_q, release_q, long_q;

    assign pol_s = (ACTIVE_LOW != 0) ? ~btn_raw[i] : btn_raw[i];
    assign s     = sync_q[SYNC_STAGES-1];

    // Synchroniser chain; resets to "not pressed" so a held button re-debounces.
    always_ff @(posedge clk_27mhz or negedge reset_n) begin
      if (!reset_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], pol_s};
      end
    end

    // Stable-time filter: any disagreement shorter than the window restarts it.
    always_comb begin
      db_cnt_d = db_cnt_q;
      db_d     = db_q;
      if (s == db_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        db_d     = s;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DBW'(1);
      end
    end

    // Debounce state registers.
    always_ff @(posedge clk_27mhz or negedge reset_n) begin
      if (!reset_n) begin
        db_cnt_q <= '0;
        db_q     <= 1'b0;
      end else begin
        db_cnt_q <= db_cnt_d;
        db_q     <= db_d;
      end
    end

    // Per-channel event FSM; a falling level is checked first so release wins.
    always_ff @(posedge clk_27mhz or negedge reset_n) begin
      if (!reset_n) begin
        state_q    <= ST_IDLE;
        hold_cnt_q <= '0;
        rpt_cnt_q  <= '0;
        held_q     <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
      end else begin
        held_q    <= db_q;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (db_q) begin
              state_q    <= ST_HELD;
              press_q    <= 1'b1;
              hold_cnt_q <= '0;
              rpt_cnt_q  <= '0;
            end
          end
          ST_HELD: begin
            if (!db_q) begin
              state_q    <= ST_IDLE;
              release_q  <= 1'b1;
              hold_cnt_q <= '0;
              rpt_cnt_q  <= '0;
            end else if (hold_cnt_q == HOLD_LAST) begin
              state_q   <= ST_LONG;
              long_q    <= 1'b1;
              rpt_cnt_q <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q + HCW'(1);
            end
          end
          ST_LONG: begin
            if (!db_q) begin
              state_q    <= ST_IDLE;
              release_q  <= 1'b1;
              hold_cnt_q <= '0;
              rpt_cnt_q  <= '0;
            end else if (!repeat_en[i]) begin
              rpt_cnt_q <= '0;
            end else if (rpt_cnt_q == RPT_LAST) begin
              press_q   <= 1'b1;
              rpt_cnt_q <= '0;
            end else begin
              rpt_cnt_q <= rpt_cnt_q + RCW'(1);
            end
          end
          default: begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            rpt_cnt_q  <= '0;
          end
        endcase
      end
    end

    assign held[i]       = held_q;
    assign press[i]      = press_q;
    assign release_o[i]  = release_q;
    assign long_press[i] = long_q;
  end

endmodule
